clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
//  Multi-channel programmable clock-enable / divided-clock generator.
//  Replaces the fixed per-instance dividers in the top level with one bank.
//  Each channel has its own runtime-loadable divisor and produces two outputs:
//  a 50%-duty divided square wave and a single-cycle tick.
//  Sits next to the OLED/mouse blocks and feeds their pixel, animation and 1 kHz timing.
// PARAMETERS
//  NUM_CH   4   number of independent channels (1..16)
//  CNT_W    32  counter and divisor width in bits
//  RESET_M  7   divisor loaded into every channel at reset (7 gives 6.25 MHz from 100 MHz)
// PORTS
//  clk       in   1               system clock (100 MHz)
//  reset     in   1               asynchronous, active-high reset
//  en        in   NUM_CH          per-channel count enable
//  load      in   1               one-cycle strobe that writes load_m into channel load_ch
//  load_ch   in   max(1,$clog2(NUM_CH))  target channel index for load
//  load_m    in   CNT_W           new divisor M
//  sync_all  in   1               phase-align strobe; used only with CLK_DIV_PHASE_SYNC_EN
//  clk_out   out  NUM_CH          divided square wave, period 2*(M+1) clk cycles
//  tick      out  NUM_CH          one-clk pulse every M+1 enabled cycles
// BEHAVIOUR
//  State per channel i: cnt[i] and m_reg[i], each CNT_W bits wide.
//  Reset (asynchronous): cnt=0, m_reg=RESET_M, clk_out=0, tick=0 on all channels.
//  Each rising clk edge, per channel, apply the first matching case, in this priority:
//   1. load && load_ch==i:
//      - m_reg<=load_m, cnt<=0.
//      - clk_out holds; tick<=0.
//      - Load wins over a coincident terminal count: no toggle, no tick that cycle.
//   2. !en[i]:
//      - cnt and clk_out hold; tick<=0.
//   3. cnt==m_reg:
//      - cnt<=0; clk_out<=~clk_out; tick<=1.
//   4. Otherwise:
//      - cnt<=cnt+1; tick<=0.
//  Outputs are registered. tick and the clk_out edge occur on the same clk edge.
//  Latency:
//   - After reset release with en high, the first tick and first clk_out rise occur
//     on the (M+1)th clk edge.
//   - After a load, the new period starts counting from 0 on the next edge.
//  Boundary conditions:
//   - M=0: clk_out toggles every cycle (clk/2); tick stays high continuously while en is high.
//   - load_ch>=NUM_CH: the load is ignored; no channel changes.
//   - If cnt>m_reg (not reachable by design, only via a forced state):
//     count up, wrap modulo 2^CNT_W, then hit terminal normally.
//   - A load on one channel never disturbs the other channels.
//  Reset mid-period: all channel state returns to reset values immediately,
//  without waiting for a clock edge.
// CONFIGURATION
//  Optional feature macro: CLK_DIV_PHASE_SYNC_EN
//  With CLK_DIV_PHASE_SYNC_EN defined:
//   - sync_all high at a clk edge sets cnt<=0, clk_out<=0, tick<=0 on all channels.
//   - sync_all takes priority over the en-hold, terminal and count cases; m_reg is kept.
//   - If load and sync_all are both asserted: m_reg takes load_m and all channels
//     are phase-aligned.
//  Without the macro:
//   - sync_all is ignored (the port is still present and left unconnected in logic).
//   - The lint waiver for the unused input lives in the file.
// TESTING
//  - Reset: assert reset mid-count -> clk_out=0, tick=0 immediately; after release,
//    first tick on edge 8 (M=7).
//  - Defaults: en=4'hF, M=7 -> tick every 8 cycles; clk_out period 16 cycles at 50% duty
//    on all channels.
//  - Mid-run load:
//    - stimulus: load ch1 with M=1 at cycle 20;
//    - ch1: cnt restarts, clk_out period 4, tick every 2 cycles;
//    - ch0, ch2, ch3: phase unchanged.
//  - Hold/collision:
//    - en[2]=0 for 5 cycles -> ch2 frozen, no tick;
//    - load ch3 on its terminal cycle -> no toggle, no tick;
//    - load_ch=5 with NUM_CH=4 -> ignored.
//  - M=0: load ch0 M=0 -> clk_out toggles every edge, tick constantly 1; en[0]=0 -> tick 0.
//  - Macro on: sync_all pulse at cycle 13 -> all cnt=0, clk_out=0; subsequent edges coincide
//    across channels that share the same M.
//  - Macro off: the same sync_all pulse -> no effect on any channel.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers: per-channel divided square wave and tick.
// Optional CLK_DIV_PHASE_SYNC_EN enables the sync_all phase-align strobe.
module clk_div_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int RESET_M = 7,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
   input  logic              load,
   input  logic [CH_W-1:0]   load_ch,
   input  logic [CNT_W-1:0]  load_m,
   input  logic              sync_all,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CNT_W-1:0]  m_q   [NUM_CH];
   logic [CNT_W-1:0]  m_d   [NUM_CH];
   logic [NUM_CH-1:0] clk_out_q, clk_out_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic              sync_hit;

`ifdef CLK_DIV_PHASE_SYNC_EN
   assign sync_hit = sync_all;
`else
   logic unused_sync_all;
   assign unused_sync_all = sync_all;
   assign sync_hit = 1'b0;
`endif

   // An out-of-range load_ch matches no channel, so the load is dropped.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]     = cnt_q[i];
         m_d[i]       = m_q[i];
         clk_out_d[i] = clk_out_q[i];
         tick_d[i]    = 1'b0;
         if (sync_hit) begin
            cnt_d[i]     = '0;
            clk_out_d[i] = 1'b0;
            if (load && (load_ch == CH_W'(i)))
               m_d[i] = load_m;
         end else if (load && (load_ch == CH_W'(i))) begin
            m_d[i]   = load_m;
            cnt_d[i] = '0;
         end else if (!en[i]) begin
            cnt_d[i] = cnt_q[i];
         end else if (cnt_q[i] == m_q[i]) begin
            cnt_d[i]     = '0;
            clk_out_d[i] = ~clk_out_q[i];
            tick_d[i]    = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
            m_q[i]   <= CNT_W'(RESET_M);
         end
         clk_out_q <= '0;
         tick_q    <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            m_q[i]   <= m_d[i];
         end
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized self-checking bench for clk_div_bank against an arithmetic model.
module tb_clk_div_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  en;
   logic        load;
   logic [1:0]  load_ch;
   logic [31:0] load_m;
   logic        sync_all;
   logic [3:0]  clk_out, tick;
   logic [2:0]  clk_out3, tick3;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int first_tick = -1;

   // Model: enabled edges since the period restarted, plus output level then.
   longint k [4];
   longint mm [4];
   bit     base [4];
   bit     co [4];
   bit     tk [4];
   longint e3;

   always #5 clk = ~clk;

   clk_div_bank u_dut (
      .clk(clk), .reset(reset), .en(en), .load(load),
      .load_ch(load_ch), .load_m(load_m), .sync_all(sync_all),
      .clk_out(clk_out), .tick(tick)
   );

   // Three channels with a 2-bit index: load_ch=3 is out of range.
   clk_div_bank #(.NUM_CH(3), .CNT_W(8), .RESET_M(7)) u_dut3 (
      .clk(clk), .reset(reset), .en(3'b111), .load(load),
      .load_ch(2'd3), .load_m(load_m[7:0]), .sync_all(1'b0),
      .clk_out(clk_out3), .tick(tick3)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         k[i] = 0; mm[i] = 7; base[i] = 0; co[i] = 0; tk[i] = 0;
      end
      e3 = 0;
   endtask

   task automatic model_step();
      bit hit;
      for (int i = 0; i < 4; i++) begin
         hit = load && (load_ch == 2'(i));
`ifdef CLK_DIV_PHASE_SYNC_EN
         if (sync_all) begin
            k[i] = 0; base[i] = 0; co[i] = 0; tk[i] = 0;
            if (hit) mm[i] = longint'(load_m);
            continue;
         end
`endif
         if (hit) begin
            mm[i] = longint'(load_m); base[i] = co[i]; k[i] = 0; tk[i] = 0;
         end else if (!en[i]) begin
            tk[i] = 0;
         end else begin
            k[i]++;
            tk[i] = (k[i] % (mm[i] + 1)) == 0;
            co[i] = base[i] ^ bit'((k[i] / (mm[i] + 1)) % 2);
         end
      end
      e3++;
   endtask

   task automatic compare();
      logic [3:0] ec, et;
      for (int i = 0; i < 4; i++) begin
         ec[i] = co[i];
         et[i] = tk[i];
      end
      check("clk_out", 32'(clk_out), 32'(ec));
      check("tick", 32'(tick), 32'(et));
      check("oor_tick", 32'(tick3), (e3 % 8 == 0) ? 32'h7 : 32'h0);
      check("oor_clk", 32'(clk_out3), ((e3 / 8) % 2 == 1) ? 32'h7 : 32'h0);
      if (first_tick < 0 && tick[0]) first_tick = cyc;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      cyc++;
      #1 compare();
      @(negedge clk);
      load = 1'b0;
      sync_all = 1'b0;
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < 4; i++) en[i] = ($urandom % 8) != 0;
      load     = ($urandom % 6) == 0;
      load_ch  = 2'($urandom % 4);
      load_m   = 32'($urandom % 10);
      sync_all = ($urandom % 40) == 0;
   endtask

   initial begin
      reset = 1'b1; en = 4'h0; load = 1'b0; load_ch = '0;
      load_m = '0; sync_all = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_clk", 32'(clk_out), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      reset = 1'b0;
      en = 4'hF;

      for (int c = 1; c <= 40; c++) begin
         if (c == 13) sync_all = 1'b1;
         if (c == 20) begin
            load = 1'b1; load_ch = 2'd1; load_m = 32'd1;
         end
         step();
      end
      check("first_tick", 32'(first_tick), 32'd8);

      en = 4'hB;
      for (int c = 0; c < 5; c++) step();
      en = 4'hF;

      for (int c = 0; c < 20; c++) begin
         if ((k[3] + 1) % (mm[3] + 1) == 0) break;
         step();
      end
      load = 1'b1; load_ch = 2'd3; load_m = 32'd3;
      step();
      check("collide_tick3", 32'(tick[3]), 32'h0);

      load = 1'b1; load_ch = 2'd0; load_m = 32'd0;
      step();
      for (int c = 0; c < 6; c++) step();
      check("m0_tick", 32'(tick[0]), 32'h1);
      en = 4'hE;
      step();
      check("m0_off", 32'(tick[0]), 32'h0);
      en = 4'hF;

      for (int c = 0; c < 800; c++) begin
         randomize_inputs();
         step();
      end

      #2 reset = 1'b1;
      #1;
      check("mid_rst_clk", 32'(clk_out), 32'h0);
      check("mid_rst_tick", 32'(tick), 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      en = 4'hF;
      first_tick = -1;
      cyc = 0;
      for (int c = 0; c < 10; c++) step();
      check("rst_first_tick", 32'(first_tick), 32'd8);

      for (int c = 0; c < 300; c++) begin
         randomize_inputs();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
